// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and counter sizing.
package subtrator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit counter must hold 0..width without wrapping.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/subtrator_completo.sv
// Combinational full subtractor cell: diff = a - b - bin, with borrow out.
module subtrator_completo (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock.
// Optional signed-overflow output enabled by SUBTRATOR_SERIAL_OVF_EN.
module subtrator_serial
  import subtrator_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SUBTRATOR_SERIAL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             bi_q, bi_d;
  logic             borrow_q, borrow_d;
  logic             d, bo;

`ifdef SUBTRATOR_SERIAL_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  subtrator_completo u_cell (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .bin  (bi_q),
    .diff (d),
    .bout (bo)
  );

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    part_d   = part_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bi_d     = bi_q;
    borrow_d = borrow_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          sa_d    = a;
          sb_d    = b;
          part_d  = '0;
          cnt_d   = '0;
          bi_d    = 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        sa_d   = sa_q >> 1;
        sb_d   = sb_q >> 1;
        bi_d   = bo;
        cnt_d  = cnt_q + CntW'(1);
        part_d = {d, part_q[WIDTH-1:1]};
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // Last step: d is the result MSB, bo the final borrow.
          state_d  = ST_DONE;
          diff_d   = {d, part_q[WIDTH-1:1]};
          borrow_d = bo;
`ifdef SUBTRATOR_SERIAL_OVF_EN
          ovf_d    = (a_msb_q ^ b_msb_q) & (d ^ a_msb_q);
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      part_q   <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bi_q     <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      part_q   <= part_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bi_q     <= bi_d;
      borrow_q <= borrow_d;
`ifdef SUBTRATOR_SERIAL_OVF_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SUBTRATOR_SERIAL_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_serial.sv
// Self-checking bench for subtrator_serial: WIDTH=8 vectors, corner sequences, random ops,
// and an exhaustive WIDTH=2 instance. Honours SUBTRATOR_SERIAL_OVF_EN when defined.
module tb_subtrator_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, borrow8;
  logic [7:0] diff8;
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0, b2 = '0;
  logic       busy2, done2, borrow2;
  logic [1:0] diff2;
  logic       ovf8, ovf2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

`ifdef SUBTRATOR_SERIAL_OVF_EN
  subtrator_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );
  subtrator_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2), .ovf(ovf2)
  );
`else
  subtrator_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );
  subtrator_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .borrow(borrow2)
  );
  assign ovf8 = 1'b0;
  assign ovf2 = 1'b0;
`endif

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       bw;
    logic       ov;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and two's-complement views.
  function automatic void ref_sub(input int w, input int x, input int y,
                                  output int rd, output int rb, output int ro);
    int sx, sy, r, half;
    half = 1 << (w - 1);
    rd = (x - y) & ((1 << w) - 1);
    rb = (x < y) ? 1 : 0;
    sx = (x >= half) ? x - (1 << w) : x;
    sy = (y >= half) ? y - (1 << w) : y;
    r  = sx - sy;
    ro = (r < -half || r >= half) ? 1 : 0;
  endfunction

  // Launch one op on dut8; return cycles from accepting edge to done and busy-cycle count.
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, output int lat,
                     output int bcnt);
    @(negedge clk);
    a8 = ta; b8 = tb; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 20) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op2(input logic [1:0] ta, input logic [1:0] tb, output int lat);
    @(negedge clk);
    a2 = ta; b2 = tb; start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, n, rd, rb, ro;
    logic [7:0] ra, rbv;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 8'h7E, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy8), 0);
    chk("reset_done", int'(done8), 0);
    chk("reset_diff", int'(diff8), 0);
    chk("reset_borrow", int'(borrow8), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 8);
      chk($sformatf("vec%0d_diff", i), int'(diff8), int'(vecs[i].d));
      chk($sformatf("vec%0d_borrow", i), int'(borrow8), int'(vecs[i].bw));
`ifdef SUBTRATOR_SERIAL_OVF_EN
      chk($sformatf("vec%0d_ovf", i), int'(ovf8), int'(vecs[i].ov));
`endif
    end

    // Start pulse during SHIFT must be dropped; outputs hold afterwards.
    @(negedge clk);
    a8 = 8'h00; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignored_start_done_seen", int'(done8), 1);
    chk("ignored_start_diff", int'(diff8), 8'h01);
    chk("ignored_start_borrow", int'(borrow8), 1);
    repeat (3) @(negedge clk);
    chk("hold_done_low", int'(done8), 0);
    chk("hold_diff", int'(diff8), 8'h01);
    chk("hold_borrow", int'(borrow8), 1);

    // Asynchronous reset mid-SHIFT aborts without a done pulse.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy8), 0);
    chk("abort_diff", int'(diff8), 0);
    chk("abort_borrow", int'(borrow8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) n++;
    end
    chk("abort_no_done", n, 0);
    op8(8'hAA, 8'h55, lat, bcnt);
    chk("after_abort_diff", int'(diff8), 8'h55);
    chk("after_abort_borrow", int'(borrow8), 0);

    // start held high: restart at first IDLE cycle with operands present then.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
    n = 0;
    while (!done8 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_diff", int'(diff8), 8'h02);
    a8 = 8'h09; b8 = 8'h04;
    n = 0;
    @(negedge clk);
    n++;
    while (!done8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    start8 = 1'b0;
    chk("b2b_period", n, 10);
    chk("b2b_second_diff", int'(diff8), 8'h05);
    chk("b2b_second_borrow", int'(borrow8), 0);

    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom_range(0, 255));
      rbv = 8'($urandom_range(0, 255));
      op8(ra, rbv, lat, bcnt);
      ref_sub(8, int'(ra), int'(rbv), rd, rb, ro);
      chk($sformatf("rand%0d_latency", i), lat, 8);
      chk($sformatf("rand%0d_diff_%02h_%02h", i, ra, rbv), int'(diff8), rd);
      chk($sformatf("rand%0d_borrow_%02h_%02h", i, ra, rbv), int'(borrow8), rb);
`ifdef SUBTRATOR_SERIAL_OVF_EN
      chk($sformatf("rand%0d_ovf", i), int'(ovf8), ro);
`endif
    end

    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        op2(2'(x), 2'(y), lat);
        ref_sub(2, x, y, rd, rb, ro);
        chk($sformatf("w2_latency_%0d_%0d", x, y), lat, 2);
        chk($sformatf("w2_diff_%0d_%0d", x, y), int'(diff2), rd);
        chk($sformatf("w2_borrow_%0d_%0d", x, y), int'(borrow2), rb);
`ifdef SUBTRATOR_SERIAL_OVF_EN
        chk($sformatf("w2_ovf_%0d_%0d", x, y), int'(ovf2), ro);
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
